reaction_ctrl: RTL

Sequencing controller for the lab's millisecond counter in the reaction-timer game. It generates the 1 ms enable pulses, clears the counter, inserts a pseudo-random wait before lighting the stimulus LED, and stops on the player's press. It latches the reaction time and tracks the best score, and its outputs feed the HEX display mux. It sits between the push-button inputs and the 20-bit ms counter, driving that counter's clear and enable inputs.

---
 rtl/reaction_pkg.sv | 40 ++++
 rtl/reaction_ctrl_key_sync.sv | 29 ++
 rtl/reaction_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction-timer controller.
//   - state_t       : controller FSM states
//   - LFSR_SEED/TAPS: 16-bit Galois LFSR seed and feedback mask (taps 16,14,13,11)
//   - DIV_MAX       : tick divider terminal count for the default clock/tick rates
//   - calc_div_max  : terminal count for arbitrary CLK_HZ/TICK_HZ
//   - calc_dly_w    : width of the random-delay register
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WAIT = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_FOUL = 3'd5,
        S_TOUT = 3'd6
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form: bit k of the mask feeds tap (k+1).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEF_TICK_HZ = 1000;
    localparam int DIV_MAX     = DEF_CLK_HZ / DEF_TICK_HZ - 1;

    function automatic int calc_div_max(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz - 1;
    endfunction

    // Must hold MIN_DELAY_MS + 2^RAND_BITS - 1.
    function automatic int calc_dly_w(input int min_ms, input int rand_bits);
        int a;
        int b;
        a = rand_bits + 1;
        b = $clog2(min_ms + (1 << rand_bits));
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reaction_ctrl_key_sync.sv
// key_sync: 2-flop synchronizer plus falling-edge detector for an active-low key.
//   clk, reset_n : clock, async active-low reset
//   key_n        : raw key, active-low, asynchronous to clk
//   press        : one-clk pulse per press (held key gives one pulse)
module key_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    logic sync1, sync2, prev;

    // Reset to the released level so no spurious press follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = prev & ~sync2;

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: sequencer for the reaction-timer game's millisecond counter.
//   clk, reset_n  : clock, async active-low reset
//   start_n       : raw start key (active-low, async)
//   stop_n        : raw react key (active-low, async)
//   ms_count      : current value of the external ms counter
//   count_clr_n   : active-low counter clear, one clk per trial
//   count_en      : counter increment pulse, one per tick while running
//   led           : stimulus LED
//   result, best  : last and best reaction times (ms)
//   best_valid    : best holds a real score
//   foul, timeout : trial ended by early press / by reaching MAX_MS
//   busy          : controller has left IDLE
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 999_999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_n,
    input  logic        stop_n,
    input  logic [19:0] ms_count,
    output logic        count_clr_n,
    output logic        count_en,
    output logic        led,
    output logic [19:0] result,
    output logic [19:0] best,
    output logic        best_valid,
    output logic        foul,
    output logic        timeout,
    output logic        busy
);

    localparam int DIV_TC = calc_div_max(CLK_HZ, TICK_HZ);
    localparam int DIV_W  = (DIV_TC > 0) ? $clog2(DIV_TC + 1) : 1;
    localparam int DLY_W  = calc_dly_w(MIN_DELAY_MS, RAND_BITS);

    state_t             state;
    logic               start_p, stop_p;
    logic [15:0]        lfsr;
    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [DLY_W-1:0]   delay;
    logic               best_upd;

    key_sync u_start (.clk(clk), .reset_n(reset_n), .key_n(start_n), .press(start_p));
    key_sync u_stop  (.clk(clk), .reset_n(reset_n), .key_n(stop_n),  .press(stop_p));

    // Free-running LFSR; the value sampled at start_p sets the wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    // Tick divider; zeroed in ARM so the first tick lands one full period later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div <= '0;
        else if (state == S_ARM || div == DIV_W'(DIV_TC))
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign tick = (div == DIV_W'(DIV_TC));

    // Stop wins over a coincident tick, so the latched result is the pre-tick count.
    assign count_en = (state == S_RUN) && tick && !stop_p;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            delay       <= '0;
            count_clr_n <= 1'b1;
            led         <= 1'b0;
            result      <= '0;
            best        <= '0;
            best_valid  <= 1'b0;
            foul        <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            best_upd    <= 1'b0;
        end else begin
            count_clr_n <= 1'b1;
            best_upd    <= 1'b0;

            // Runs on the DONE entry cycle, once result already holds the new time.
            if (best_upd) begin
                if (!best_valid || result < best)
                    best <= result;
                best_valid <= 1'b1;
            end

            case (state)
                S_IDLE, S_DONE, S_FOUL, S_TOUT: begin
                    if (start_p) begin
                        state       <= S_ARM;
                        delay       <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);
                        foul        <= 1'b0;
                        timeout     <= 1'b0;
                        count_clr_n <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_ARM: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (stop_p) begin
                        state <= S_FOUL;
                        foul  <= 1'b1;
                    end else if (tick) begin
                        // Guarding <=1 keeps a zero load from wrapping.
                        if (delay <= DLY_W'(1)) begin
                            state <= S_RUN;
                            led   <= 1'b1;
                        end
                        delay <= delay - 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop_p) begin
                        state    <= S_DONE;
                        led      <= 1'b0;
                        result   <= ms_count;
                        best_upd <= 1'b1;
                    end else if (ms_count == 20'(MAX_MS)) begin
                        state   <= S_TOUT;
                        led     <= 1'b0;
                        timeout <= 1'b1;
                        result  <= 20'(MAX_MS);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    led   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
